// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory stage of the core pipeline.
//
// Holds the EX/MEM pipeline latch and a load/store unit that talks to data
// memory over a request/grant/response handshake. Stores are formatted into
// byte lanes and load data is extracted and sign/zero extended. While an
// access is outstanding, stall tells execute to hold its outputs and tells
// writeback not to capture.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   branch_taken_in, rdn_in,  execute-stage results, captured when stall=0
//   pc_in, branch_addr_in,
//   rs2d_in, alu_out_in       (alu_out_in is the effective address of mem ops)
//   mem_en, mem_we,           memory op controls: enable, 1=store/0=load,
//   mem_size, mem_unsigned    size (00 byte, 01 half, 10 word, 11 illegal),
//                             zero-extend loads
//   dmem_req, dmem_we,        data-memory request, driven from latch registers
//   dmem_addr, dmem_wdata,
//   dmem_be
//   dmem_gnt, dmem_rvalid,    data-memory grant and load response
//   dmem_rdata
//   branch_taken, rdn, pc,    latched copies for writeback
//   branch_addr
//   wb_data                   load data while waiting on memory, else alu_out
//   misaligned                latched op is a misaligned or illegal mem op
//   stall                     upstream hold / downstream do-not-capture
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int WordSize = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  branch_taken_in,
    input  logic [4:0]            rdn_in,
    input  logic [WordSize-1:0]   pc_in,
    input  logic [WordSize-1:0]   branch_addr_in,
    input  logic [WordSize-1:0]   rs2d_in,
    input  logic [WordSize-1:0]   alu_out_in,
    input  logic                  mem_en,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WordSize-1:0]   dmem_addr,
    output logic [WordSize-1:0]   dmem_wdata,
    output logic [WordSize/8-1:0] dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [WordSize-1:0]   dmem_rdata,
    output logic                  branch_taken,
    output logic [4:0]            rdn,
    output logic [WordSize-1:0]   pc,
    output logic [WordSize-1:0]   branch_addr,
    output logic [WordSize-1:0]   wb_data,
    output logic                  misaligned,
    output logic                  stall
);

    localparam int Lanes = WordSize / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_branch_taken;
    logic [4:0]            r_rdn;
    logic [WordSize-1:0]   r_pc;
    logic [WordSize-1:0]   r_branch_addr;
    logic [WordSize-1:0]   r_rs2d;
    logic [WordSize-1:0]   r_alu_out;
    logic                  r_mem_we;
    logic [1:0]            r_mem_size;
    logic                  r_mem_unsigned;
    logic                  r_misaligned;

    logic                  w_illegal;
    logic                  w_cap_mem;
    logic                  w_stall;
    logic [7:0]            w_rbyte;
    logic [15:0]           w_rhalf;
    logic [WordSize-1:0]   w_load_data;
    logic [WordSize-1:0]   w_wdata;
    logic [Lanes-1:0]      w_be;

    // Alignment check on the incoming op
    always_comb begin
        w_illegal = 1'b0;
        case (mem_size)
            2'b00:   w_illegal = 1'b0;
            2'b01:   w_illegal = alu_out_in[0];
            2'b10:   w_illegal = (alu_out_in[1:0] != 2'b00);
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_cap_mem = mem_en & ~w_illegal;

    // EX/MEM latch: captures on every edge the stage is not stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_branch_taken <= 1'b0;
            r_rdn          <= '0;
            r_pc           <= '0;
            r_branch_addr  <= '0;
            r_rs2d         <= '0;
            r_alu_out      <= '0;
            r_mem_we       <= 1'b0;
            r_mem_size     <= '0;
            r_mem_unsigned <= 1'b0;
            r_misaligned   <= 1'b0;
        end else if (!w_stall) begin
            r_branch_taken <= branch_taken_in;
            // An illegal mem op must not write back, so its rd is squashed
            r_rdn          <= (mem_en && w_illegal) ? '0 : rdn_in;
            r_pc           <= pc_in;
            r_branch_addr  <= branch_addr_in;
            r_rs2d         <= rs2d_in;
            r_alu_out      <= alu_out_in;
            r_mem_we       <= mem_we;
            r_mem_size     <= mem_size;
            r_mem_unsigned <= mem_unsigned;
            r_misaligned   <= mem_en && w_illegal;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and stall. Whenever the stage is not stalled a new op is
    // captured on the same edge, so the completing cycle of one access can
    // launch the next straight into REQ.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_REQ: begin
                w_stall = ~(dmem_gnt & r_mem_we);
                if (dmem_gnt && !r_mem_we) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stall = ~dmem_rvalid;
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
        if (!w_stall) begin
            w_state_next = w_cap_mem ? ST_REQ : ST_IDLE;
        end
    end

    // Store formatting: data replicated across lanes, enables select lanes
    always_comb begin
        w_wdata = r_rs2d;
        w_be    = '1;
        case (r_mem_size)
            2'b00: begin
                w_wdata = {Lanes{r_rs2d[7:0]}};
                w_be    = {{(Lanes-1){1'b0}}, 1'b1} << r_alu_out[1:0];
            end
            2'b01: begin
                w_wdata = {(Lanes/2){r_rs2d[15:0]}};
                w_be    = r_alu_out[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = r_rs2d;
                w_be    = '1;
            end
        endcase
    end

    // Load extraction
    assign w_rbyte = dmem_rdata[{r_alu_out[1:0], 3'b000} +: 8];
    assign w_rhalf = dmem_rdata[{r_alu_out[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = dmem_rdata;
        case (r_mem_size)
            2'b00: w_load_data = r_mem_unsigned ? {{(WordSize-8){1'b0}}, w_rbyte}
                                                : {{(WordSize-8){w_rbyte[7]}}, w_rbyte};
            2'b01: w_load_data = r_mem_unsigned ? {{(WordSize-16){1'b0}}, w_rhalf}
                                                : {{(WordSize-16){w_rhalf[15]}}, w_rhalf};
            default: w_load_data = dmem_rdata;
        endcase
    end

    assign dmem_req     = (r_state == ST_REQ);
    assign dmem_we      = r_mem_we;
    assign dmem_addr    = {r_alu_out[WordSize-1:2], 2'b00};
    assign dmem_wdata   = w_wdata;
    assign dmem_be      = w_be;

    assign branch_taken = r_branch_taken;
    assign rdn          = r_rdn;
    assign pc           = r_pc;
    assign branch_addr  = r_branch_addr;
    assign wb_data      = (r_state == ST_WAIT) ? w_load_data : r_alu_out;
    assign misaligned   = r_misaligned;
    assign stall        = w_stall;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the core pipeline, sitting directly downstream of the execute stage. It contains the EX/MEM pipeline latch and a load/store unit that runs a request/grant/response handshake with data memory. Stores are formatted into byte lanes, and load data is extracted and sign- or zero-extended. Results go to the MEM/WB latch, and `stall` is raised back to the execute stage while a memory access is outstanding.

## Interface
- `WordSize`, 32, datapath width; byte lanes = `WordSize/8`; only 32 is supported and verified
- `clk` in 1: rising-edge clock
- `rstn` in 1: reset; one clock, asynchronous, active-low
- `branch_taken_in` in 1: from execute stage
- `rdn_in` in 5: destination register number
- `pc_in`, `branch_addr_in`, `rs2d_in`, `alu_out_in` in `WordSize`: from execute stage; `alu_out_in` is the effective address for memory ops
- `mem_en` in 1: op is a load or store
- `mem_we` in 1: 1 = store, 0 = load
- `mem_size` in 2: 00 byte, 01 half, 10 word, 11 illegal
- `mem_unsigned` in 1: zero-extend loads
- `dmem_req` out 1: request valid
- `dmem_we` out 1: request is a write
- `dmem_addr` out `WordSize`: word-aligned address (low 2 bits 0)
- `dmem_wdata` out `WordSize`: lane-replicated store data
- `dmem_be` out 4: byte enables
- `dmem_gnt` in 1: request accepted this cycle
- `dmem_rvalid` in 1: load data valid
- `dmem_rdata` in `WordSize`: load data
- `branch_taken`, `rdn`, `pc`, `branch_addr` out: latched copies of the inputs
- `wb_data` out `WordSize`: result for writeback
- `misaligned` out 1: latched op is misaligned or illegal
- `stall` out 1: upstream must hold; downstream must not capture

## Operation
- Latch: on each rising edge with `stall`=0, capture all `*_in` inputs and the mem controls. With `stall`=1, hold all latch contents.
- Alignment check at capture:
  - half is illegal when addr[0]=1
  - word is illegal when addr[1:0]≠0
  - `mem_size`=11 is always illegal
  - An illegal mem op sets registered `misaligned`=1, issues no request, and forces `rdn` output to 0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE→REQ: at a capture edge when a legal mem op is captured.
  - REQ, store: on `dmem_gnt`, go to IDLE.
  - REQ, load: on `dmem_gnt`, go to WAIT.
  - WAIT: on `dmem_rvalid`, go to IDLE.
  - A capture in the completing cycle may re-enter REQ directly.
- `dmem_req` = (state==REQ). `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_be` come from latch registers and are stable while `dmem_req`=1 and `dmem_gnt`=0.
- Store formatting:
  - byte: wdata={4{rs2d[7:0]}}, be=0001<<addr[1:0]
  - half: wdata={2{rs2d[15:0]}}, be=0011 (addr[1]=0) or 1100 (addr[1]=1)
  - word: wdata=rs2d, be=1111
- Load extraction from `dmem_rdata`:
  - byte: lane addr[1:0]
  - half: lane addr[1]
  - sign-extend unless `mem_unsigned`=1; word passes through
- `wb_data`: extracted load data while state==WAIT, otherwise the latched `alu_out`.
- `stall` is combinational and equals (REQ and not (`dmem_gnt` and store)) or (REQ and load) or (WAIT and not `dmem_rvalid`).
- `dmem_rvalid` is ignored outside WAIT. `dmem_gnt` is ignored outside REQ.

## Timing
- Reset (async, immediate) drives the following, regardless of an outstanding access:
  - all latch outputs, `wb_data` and `misaligned` to 0
  - state to IDLE, so `dmem_req`=0 and `stall`=0
  - A late `rvalid` after reset is ignored.
- Non-mem op: zero added latency. Outputs are valid the cycle after capture, and `stall` stays 0.
- Store: `dmem_req` rises the cycle after capture. `stall`=0 in the grant cycle, so the best case is no stall cycle.
- Load: `dmem_req` rises the cycle after capture. `stall`=1 through the grant cycle. `rvalid` arrives no earlier than the cycle after grant. `stall`=0 in the `rvalid` cycle, when `wb_data` is valid. Best case is 1 stall cycle.
- Back-to-back mem ops: the next op is captured at the completing edge, and its `dmem_req` rises the following cycle.

## Test plan
- ALU op, `alu_out_in`=0x1234, `rdn_in`=5 -> next cycle `wb_data`=0x1234, `rdn`=5, `stall`=0, `dmem_req`=0.
- Store byte, addr 0x103, `rs2d_in`=0xAB, gnt on first req cycle -> `dmem_addr`=0x100, `be`=1000, `wdata`=0xABABABAB, `stall` never 1.
- Load half signed, addr 0x102, gnt delayed 2 cycles, `rdata`=0x80FF0000 two cycles after gnt -> `stall` high until the `rvalid` cycle, then `wb_data`=0xFFFF80FF. The same access with `mem_unsigned`=1 -> 0x000080FF.
- Load word at 0x101 -> `misaligned`=1, `rdn`=0, no `dmem_req`, `stall`=0.
- Assert `rstn`=0 in WAIT -> `dmem_req`, `stall` and all outputs go to 0 immediately. A subsequent `rvalid` is ignored and the FSM stays IDLE.
- Two consecutive loads, each with 1-cycle grant and `rvalid` -> second `dmem_req` rises the cycle after the first `rvalid`. `wb_data` is correct for both, and no op is dropped or duplicated.
